cell_sweep_checker: RTL
=======================

CELL_SWEEP_CHECKER -- requirements
Module: cell_sweep_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 4, meaning wait cycles between stimulus update and response sample (legal 1..255).
REQ-002 The block SHALL have parameter BASE_ADR, default 32'h3000_0000, meaning Wishbone base address; the block decodes adr[31:4] == BASE_ADR[31:4].
REQ-003 Port wb_clk_i  in  1  single clock; all flops on rising edge.
REQ-004 Port wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 Ports wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic slave strobe, cycle, write-enable.
REQ-006 Port wbs_sel_i  in  4  byte enables; port wbs_dat_i  in  32  write data; port wbs_adr_i  in  32  byte address.
REQ-007 Port wbs_ack_o  out  1  transfer acknowledge; port wbs_dat_o  out  32  read data.
REQ-008 Port stim_o  out  4  drives inputs A,B,C,D (bits 0..3) of the standard cell under test.
REQ-009 Port resp_i  in  1  output Y of the cell under test.
REQ-010 Ports busy_o, done_o, pass_o  out  1 each  sweep in progress, sweep finished, last sweep had zero mismatches.

Function
REQ-011 Register map, word offset adr[3:2]: 0 CTRL (bits[2:0] nin, bit 4 start, write-1, self-clearing, reads 0); 1 LUT (bits[15:0] expected Y indexed by vector); 2 STATUS (read-only: bit0 busy, bit1 done, bit2 pass, bits[11:8] first failing vector, bit12 fail_valid); 3 ERRCNT (read-only, bits[15:0]).
REQ-012 A transfer SHALL be acked exactly one cycle after stb&cyc is first seen; ack SHALL be a single-cycle pulse and never high two consecutive cycles.
REQ-013 Read data SHALL be registered and valid in the ack cycle; unused bits and unmapped offsets SHALL read 0; writes to read-only offsets SHALL be ignored but acked.
REQ-014 Writes SHALL honour wbs_sel_i per byte; CTRL uses byte 0, LUT uses bytes 0-1.
REQ-015 Writes to CTRL and LUT while busy SHALL be acked and ignored, including start.
REQ-016 nin = 0 SHALL cause start to be ignored; nin > 4 SHALL be treated as 4; sweep covers vectors 0 .. 2^nin-1 ascending; stim_o bits >= nin SHALL be 0.
REQ-017 resp_i SHALL pass through a two-flop synchronizer before comparison.
REQ-018 FSM states IDLE, APPLY, WAIT, SAMPLE, DONE; IDLE->APPLY on accepted start; APPLY (1 cycle, stim_o <= vector)->WAIT (SETTLE cycles)->SAMPLE (1 cycle, compare synchronized resp with LUT[vector]); SAMPLE->APPLY with vector+1, or ->DONE after last vector; DONE->IDLE next cycle.
REQ-019 Each vector SHALL take exactly SETTLE+2 cycles; done_o SHALL rise 2^nin*(SETTLE+2) cycles after the accepting ack cycle.
REQ-020 On mismatch ERRCNT SHALL increment, saturating at 16'hFFFF; the first mismatch of a sweep SHALL latch the vector and set fail_valid.
REQ-021 Accepted start SHALL clear ERRCNT, fail_valid, first-fail vector, done and pass in the same cycle; busy_o high from the next cycle until DONE.
REQ-022 done_o and pass_o SHALL remain set until the next accepted start or reset; pass_o = (ERRCNT == 0) at DONE.
REQ-023 stim_o SHALL hold the last applied vector after the sweep finishes.

Reset
REQ-024 While wb_rst_ni is low all state SHALL clear immediately: FSM IDLE, stim_o=0, wbs_ack_o=0, wbs_dat_o=0, busy_o=0, done_o=0, pass_o=0, CTRL=0, LUT=0, ERRCNT=0, fail_valid=0.
REQ-025 Reset mid-sweep SHALL abort the sweep with no done_o pulse; first start after release SHALL behave as from power-up.

Verification
REQ-026 AND2 model (Y=A&B), LUT=16'h0008, nin=2, SETTLE=4, start -> done_o at +24 cycles, pass_o=1, ERRCNT=0, fail_valid=0.
REQ-027 resp_i stuck at 0, LUT=16'h0008, nin=2 -> ERRCNT=1, first fail vector=3, pass_o=0.
REQ-028 Inverted XOR model, LUT=16'h0006, nin=2 -> ERRCNT=4, first fail vector=0, fail_valid=1.
REQ-029 Start write during busy, and LUT write during busy -> both acked, sweep unaffected, LUT unchanged; nin=0 start -> busy_o stays 0.
REQ-030 Assert wb_rst_ni low at vector 5 of a nin=4 sweep -> all outputs 0 within the reset, no done_o; new sweep after release completes in 16*(SETTLE+2) cycles.
REQ-031 Back-to-back reads of STATUS and offset 0x0C with held stb/cyc -> ack single-cycle each; unmapped address 0x10 above BASE_ADR -> not acked.

Source files
------------

// File: rtl/cell_sweep_checker.sv
// rtl/cell_sweep_checker.sv - Wishbone-controlled truth-table sweep checker for one standard cell
// Applies every input vector to the cell, samples Y after a settle time and counts mismatches against a LUT.
module cell_sweep_checker #(
  parameter int unsigned SETTLE   = 4,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  stim_o,
  input  logic        resp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o
);

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [3:0]  vec, last_vec, last_vec_wr;
  logic [2:0]  nin;
  logic [15:0] lut;
  logic [15:0] errcnt;
  logic [3:0]  fail_vec;
  logic        fail_valid;
  logic        resp_meta, resp_sync;

  logic        hit, accept, wr, locked, ctrl_wr, lut_wr, start_ok;
  logic        mismatch, last;
  logic [1:0]  off;
  logic [31:0] rdata;
  logic        unused_bits;

  assign hit      = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  // ack is suppressed in the cycle after an ack so held strobes yield separate pulses
  assign accept   = wbs_stb_i & wbs_cyc_i & hit & ~wbs_ack_o;
  assign wr       = accept & wbs_we_i;
  assign off      = wbs_adr_i[3:2];
  assign locked   = (state != IDLE);
  assign ctrl_wr  = wr && (off == 2'd0) && wbs_sel_i[0] && !locked;
  assign lut_wr   = wr && (off == 2'd1) && !locked;
  assign start_ok = ctrl_wr && wbs_dat_i[4] && (wbs_dat_i[2:0] != 3'd0);

  assign mismatch = (state == SAMPLE) && (resp_sync != lut[vec]);
  assign last     = (vec == last_vec);
  assign busy_o   = (state == APPLY) || (state == WAIT) || (state == SAMPLE);

  assign unused_bits = ^{wbs_dat_i[31:16], wbs_dat_i[7:5], wbs_dat_i[3],
                         wbs_sel_i[3:2], wbs_adr_i[1:0]};

  // nin values above 4 sweep the full 4-input space
  always_comb begin
    last_vec_wr = 4'd15;
    case (wbs_dat_i[2:0])
      3'd1:    last_vec_wr = 4'd1;
      3'd2:    last_vec_wr = 4'd3;
      3'd3:    last_vec_wr = 4'd7;
      default: last_vec_wr = 4'd15;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (off)
      2'd0: rdata = {29'd0, nin};
      2'd1: rdata = {16'd0, lut};
      2'd2: rdata = {19'd0, fail_valid, fail_vec, 5'd0, pass_o, done_o, busy_o};
      2'd3: rdata = {16'd0, errcnt};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      nin       <= '0;
      lut       <= '0;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= (accept && !wbs_we_i) ? rdata : 32'd0;
      if (ctrl_wr) nin <= wbs_dat_i[2:0];
      if (lut_wr && wbs_sel_i[0]) lut[7:0]  <= wbs_dat_i[7:0];
      if (lut_wr && wbs_sel_i[1]) lut[15:8] <= wbs_dat_i[15:8];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      resp_meta <= 1'b0;
      resp_sync <= 1'b0;
    end else begin
      resp_meta <= resp_i;
      resp_sync <= resp_meta;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = APPLY;
      APPLY:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == 8'(SETTLE - 1)) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // stim_o is updated on entry to APPLY so the cell sees the vector for SETTLE+1 cycles before sampling
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wait_cnt   <= '0;
      vec        <= '0;
      last_vec   <= '0;
      stim_o     <= '0;
      errcnt     <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
    end else begin
      if (state == APPLY)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;

      if (start_ok) begin
        vec        <= '0;
        stim_o     <= '0;
        last_vec   <= last_vec_wr;
        errcnt     <= '0;
        fail_vec   <= '0;
        fail_valid <= 1'b0;
        done_o     <= 1'b0;
        pass_o     <= 1'b0;
      end else if (state == SAMPLE) begin
        if (mismatch) begin
          if (errcnt != 16'hFFFF) errcnt <= errcnt + 16'd1;
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= vec;
          end
        end
        if (last) begin
          done_o <= 1'b1;
          pass_o <= (errcnt == 16'd0) && !mismatch;
        end else begin
          vec    <= vec + 4'd1;
          stim_o <= vec + 4'd1;
        end
      end
    end
  end

endmodule
